// File: rtl/gpio_bus_arbiter.sv
// Two-requester round-robin arbiter in front of a GPIO register bus.
// Each transaction runs IDLE -> ACCESS -> DONE, with illegal offsets blocked before they reach the bus.
module gpio_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_done,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_done,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic              gpio_cs,
  output logic              gpio_we,
  output logic              gpio_re,
  output logic [ADDR_W-1:0] gpio_addr,
  output logic [DATA_W-1:0] gpio_wdata,
  input  logic [DATA_W-1:0] gpio_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state, next_state;
  logic              ptr, owner, lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata, resp;
  logic              any_req, winner, illegal;

  // The pointer only matters when both requesters are high at the same time.
  assign any_req = m0_req | m1_req;
  assign winner  = (m0_req && m1_req) ? ptr : m1_req;
  assign illegal = (lat_addr[3:2] == 2'b11) || (lat_we && (lat_addr[3:2] == 2'b10));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      owner     <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      resp      <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner     <= winner;
            lat_we    <= winner ? m1_we    : m0_we;
            lat_addr  <= winner ? m1_addr  : m0_addr;
            lat_wdata <= winner ? m1_wdata : m0_wdata;
          end
        end
        ACCESS: begin
          resp <= (!illegal && !lat_we) ? gpio_rdata : '0;
          ptr  <= ~owner;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    next_state = state;
    m0_gnt     = 1'b0;
    m1_gnt     = 1'b0;
    m0_done    = 1'b0;
    m1_done    = 1'b0;
    m0_rdata   = '0;
    m1_rdata   = '0;
    m0_err     = 1'b0;
    m1_err     = 1'b0;
    gpio_cs    = 1'b0;
    gpio_we    = 1'b0;
    gpio_re    = 1'b0;
    gpio_addr  = '0;
    gpio_wdata = '0;
    case (state)
      IDLE: begin
        if (any_req) next_state = ACCESS;
      end
      ACCESS: begin
        next_state = DONE;
        m0_gnt     = ~owner;
        m1_gnt     = owner;
        // An illegal access still occupies the slot but never touches the bus.
        if (!illegal) begin
          gpio_cs    = 1'b1;
          gpio_we    = lat_we;
          gpio_re    = ~lat_we;
          gpio_addr  = lat_addr;
          gpio_wdata = lat_wdata;
        end
      end
      DONE: begin
        next_state = IDLE;
        if (owner) begin
          m1_done  = 1'b1;
          m1_rdata = resp;
          m1_err   = illegal;
        end else begin
          m0_done  = 1'b1;
          m0_rdata = resp;
          m0_err   = illegal;
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Testbench for gpio_bus_arbiter: directed table, round-robin and reset sequences,
// then random traffic compared against a transaction-level reference model.
module tb_gpio_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        gpio_cs, gpio_we, gpio_re;
  logic [31:0] gpio_addr, gpio_wdata, gpio_rdata;

  int vectors = 0;
  int miscompares = 0;

  gpio_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .gpio_cs(gpio_cs), .gpio_we(gpio_we), .gpio_re(gpio_re),
    .gpio_addr(gpio_addr), .gpio_wdata(gpio_wdata), .gpio_rdata(gpio_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic        who;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd_in;
    logic        exp_cs;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic check_bit(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0;
    gpio_rdata = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One lone-requester transaction; starts and ends on a falling edge in IDLE.
  task automatic apply_stimulus(input vec_t v);
    m0_req = (v.who == 1'b0); m1_req = (v.who == 1'b1);
    m0_we = v.we; m1_we = v.we;
    m0_addr = v.addr; m1_addr = v.addr;
    m0_wdata = v.wdata; m1_wdata = v.wdata;
    gpio_rdata = v.rd_in;
    @(negedge clk);
    m0_req = 1'b0; m1_req = 1'b0;
    check_bit("tbl_m0_gnt", m0_gnt, v.who == 1'b0);
    check_bit("tbl_m1_gnt", m1_gnt, v.who == 1'b1);
    check_bit("tbl_cs", gpio_cs, v.exp_cs);
    check_bit("tbl_we", gpio_we, v.exp_cs && v.we);
    check_bit("tbl_re", gpio_re, v.exp_cs && !v.we);
    check_word("tbl_addr", gpio_addr, v.exp_cs ? v.addr : 32'h0);
    check_word("tbl_wdata", gpio_wdata, v.exp_cs ? v.wdata : 32'h0);
    @(negedge clk);
    check_bit("tbl_cs_done", gpio_cs, 1'b0);
    check_bit("tbl_m0_done", m0_done, v.who == 1'b0);
    check_bit("tbl_m1_done", m1_done, v.who == 1'b1);
    check_bit("tbl_err", v.who ? m1_err : m0_err, v.exp_err);
    check_word("tbl_rdata", v.who ? m1_rdata : m0_rdata, v.exp_rdata);
    check_word("tbl_other_rdata", v.who ? m0_rdata : m1_rdata, 32'h0);
    @(negedge clk);
    check_bit("tbl_idle_done", m0_done | m1_done, 1'b0);
  endtask

  // Reference model: a transaction sampled at edge m_s occupies cycle m_s (bus access)
  // and cycle m_s+1 (completion); the next arbitration happens at edge m_s+3.
  logic        m_have, m_owner, m_we, m_ptr;
  int          m_s, m_c;
  logic [31:0] m_addr, m_wdata, m_resp;

  function automatic logic legal(input logic we, input logic [31:0] a);
    logic [1:0] off;
    off = a[3:2];
    return !((off == 2'd3) || (we && off == 2'd2));
  endfunction

  task automatic model_reset();
    m_have = 1'b0; m_owner = 1'b0; m_we = 1'b0; m_ptr = 1'b0;
    m_s = 0; m_c = 0; m_addr = 32'h0; m_wdata = 32'h0; m_resp = 32'h0;
  endtask

  task automatic model_edge();
    m_c++;
    if (m_have && m_c == m_s + 1) begin
      m_resp = (legal(m_we, m_addr) && !m_we) ? gpio_rdata : 32'h0;
      m_ptr = !m_owner;
    end
    if ((!m_have || m_c >= m_s + 3) && (m0_req || m1_req)) begin
      m_owner = (m0_req && m1_req) ? m_ptr : m1_req;
      m_we    = m_owner ? m1_we : m0_we;
      m_addr  = m_owner ? m1_addr : m0_addr;
      m_wdata = m_owner ? m1_wdata : m0_wdata;
      m_have  = 1'b1;
      m_s     = m_c;
    end
  endtask

  task automatic check_output();
    logic acc, dn, cs;
    acc = m_have && (m_c == m_s);
    dn  = m_have && (m_c == m_s + 1);
    cs  = acc && legal(m_we, m_addr);
    check_bit("rnd_m0_gnt", m0_gnt, acc && !m_owner);
    check_bit("rnd_m1_gnt", m1_gnt, acc && m_owner);
    check_bit("rnd_cs", gpio_cs, cs);
    check_bit("rnd_we", gpio_we, cs && m_we);
    check_bit("rnd_re", gpio_re, cs && !m_we);
    check_word("rnd_addr", gpio_addr, cs ? m_addr : 32'h0);
    check_word("rnd_wdata", gpio_wdata, cs ? m_wdata : 32'h0);
    check_bit("rnd_m0_done", m0_done, dn && !m_owner);
    check_bit("rnd_m1_done", m1_done, dn && m_owner);
    check_bit("rnd_m0_err", m0_err, dn && !m_owner && !legal(m_we, m_addr));
    check_bit("rnd_m1_err", m1_err, dn && m_owner && !legal(m_we, m_addr));
    check_word("rnd_m0_rdata", m0_rdata, (dn && !m_owner) ? m_resp : 32'h0);
    check_word("rnd_m1_rdata", m1_rdata, (dn && m_owner) ? m_resp : 32'h0);
  endtask

  int gnt_cyc[$];
  logic gnt_who[$];

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    m0_req = 1'b1; m1_req = 1'b1;
    #12;
    check_bit("rst_m0_gnt", m0_gnt, 1'b0);
    check_bit("rst_m1_gnt", m1_gnt, 1'b0);
    check_bit("rst_m0_done", m0_done, 1'b0);
    check_bit("rst_m1_done", m1_done, 1'b0);
    check_bit("rst_cs", gpio_cs, 1'b0);
    check_bit("rst_we", gpio_we, 1'b0);
    check_bit("rst_re", gpio_re, 1'b0);
    check_word("rst_addr", gpio_addr, 32'h0);
    check_word("rst_m0_rdata", m0_rdata, 32'h0);
    check_word("rst_m1_rdata", m1_rdata, 32'h0);

    do_reset();
    vecs[0] = '{1'b0, 1'b1, 32'h0000_0000, 32'hA5A5_0001, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,         32'h0000_00F0, 1'b1, 1'b0, 32'h0000_00F0};
    vecs[2] = '{1'b0, 1'b1, 32'h0000_0008, 32'h1111_2222, 32'h0000_0033, 1'b0, 1'b1, 32'h0};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_000C, 32'h0,         32'h5555_AAAA, 1'b0, 1'b1, 32'h0};
    vecs[4] = '{1'b1, 1'b1, 32'h1234_0004, 32'hCAFE_F00D, 32'h0000_0077, 1'b1, 1'b0, 32'h0};
    vecs[5] = '{1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0,         32'h1357_9BDF, 1'b1, 1'b0, 32'h1357_9BDF};
    for (int i = 0; i < 6; i++) apply_stimulus(vecs[i]);

    // Both requesters held high: grants must alternate every three cycles.
    do_reset();
    m0_req = 1'b1; m1_req = 1'b1; m1_addr = 32'h4;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (m0_gnt || m1_gnt) begin
        gnt_cyc.push_back(k);
        gnt_who.push_back(m1_gnt);
        check_bit("rr_both_gnt", m0_gnt & m1_gnt, 1'b0);
      end
    end
    idle_inputs();
    check_word("rr_count", gnt_cyc.size(), 32'd6);
    for (int i = 0; i < gnt_cyc.size() && i < 6; i++) begin
      check_bit("rr_order", gnt_who[i], i[0]);
      check_word("rr_cycle", gnt_cyc[i], 1 + 3 * i);
    end
    repeat (3) @(negedge clk);

    // Reset pulled in the middle of an m1 write.
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h4; m1_wdata = 32'h0000_BEEF;
    @(negedge clk);
    m1_req = 1'b0;
    check_bit("arst_pre_gnt", m1_gnt, 1'b1);
    check_bit("arst_pre_cs", gpio_cs, 1'b1);
    check_bit("arst_pre_we", gpio_we, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_bit("arst_cs", gpio_cs, 1'b0);
    check_bit("arst_we", gpio_we, 1'b0);
    check_bit("arst_gnt", m1_gnt, 1'b0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check_bit("arst_no_done", m1_done, 1'b0);
    end
    rst_n = 1'b1;
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_bit("arst_post_done", m1_done, 1'b0);
      check_bit("arst_post_gnt", m1_gnt, 1'b0);
    end
    m1_req = 1'b1;
    @(negedge clk);
    m1_req = 1'b0;
    check_bit("arst_lone_m1", m1_gnt, 1'b1);
    check_bit("arst_lone_m0", m0_gnt, 1'b0);
    @(negedge clk);
    check_bit("arst_lone_done", m1_done, 1'b1);
    @(negedge clk);
    m0_req = 1'b1; m1_req = 1'b1;
    @(negedge clk);
    idle_inputs();
    check_bit("arst_ptr_m0", m0_gnt, 1'b1);
    repeat (3) @(negedge clk);

    // Random traffic against the reference model.
    do_reset();
    model_reset();
    for (int k = 0; k < 500; k++) begin
      check_output();
      m0_req = ($urandom_range(0, 2) != 0);
      m1_req = ($urandom_range(0, 2) != 0);
      m0_we = 1'($urandom_range(0, 1));
      m1_we = 1'($urandom_range(0, 1));
      m0_addr = $urandom; m1_addr = $urandom;
      m0_wdata = $urandom; m1_wdata = $urandom;
      gpio_rdata = $urandom;
      model_edge();
      @(negedge clk);
    end
    check_output();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gpio_bus_arbiter.md
GPIO_BUS_ARBITER -- requirements
Module: gpio_bus_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 32, address width; DATA_W, default 32, data width.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 mK_req  input  1  (K=0,1) requester K transaction request, level.
REQ-005 mK_we  input  1  requester K direction: 1 = write, 0 = read.
REQ-006 mK_addr  input  ADDR_W  requester K register address.
REQ-007 mK_wdata  input  DATA_W  requester K write data.
REQ-008 mK_gnt  output  1  one-cycle pulse: requester K's request has been accepted.
REQ-009 mK_done  output  1  one-cycle pulse: requester K's transaction has completed.
REQ-010 mK_rdata  output  DATA_W  read result; valid while mK_done=1.
REQ-011 mK_err  output  1  illegal access flag; valid while mK_done=1.
REQ-012 gpio_cs, gpio_we, gpio_re  output  1 each  register-bus strobes to the GPIO register block.
REQ-013 gpio_addr  output  ADDR_W  register-bus address.
REQ-014 gpio_wdata  output  DATA_W  register-bus write data.
REQ-015 gpio_rdata  input  DATA_W  combinational read data returned by the GPIO register block.

Function
REQ-016 The FSM SHALL have three states: IDLE, ACCESS, DONE.
REQ-017 IDLE, no mK_req high: remain in IDLE.
REQ-018 IDLE, any mK_req high: arbitrate; latch the winner's we/addr/wdata and owner ID; go to ACCESS.
REQ-019 ACCESS SHALL always last exactly one cycle, then go to DONE.
REQ-020 DONE SHALL always last exactly one cycle, then go to IDLE.
REQ-021 Arbitration SHALL be round-robin with a 1-bit priority pointer.
REQ-022 A lone requester SHALL win regardless of the pointer.
REQ-023 When both requesters are high, the requester named by the pointer SHALL win.
REQ-024 The pointer SHALL be set to the non-winner when DONE is entered.
REQ-025 mK_gnt SHALL be registered and high only during the ACCESS cycle, for the owner only.
REQ-026 mK_req SHALL be ignored in ACCESS and DONE; a req still high when IDLE is re-entered SHALL start a new transaction.
REQ-027 In ACCESS for a legal access: gpio_cs=1; gpio_we=latched we; gpio_re=~latched we; gpio_addr and gpio_wdata = latched values.
REQ-028 All gpio_* outputs SHALL be 0 in IDLE and DONE.
REQ-029 Legality SHALL be decoded from latched addr[3:2].
REQ-030 A write with addr[3:2]=2'b10 (read-only offset) SHALL be illegal.
REQ-031 Any access with addr[3:2]=2'b11 SHALL be illegal.
REQ-032 All other accesses SHALL be legal; address bits above [3:2] SHALL be forwarded unchanged.
REQ-033 For an illegal access, ACCESS SHALL keep all gpio_* outputs at 0; only mK_err differs from a legal access.
REQ-034 At the end of ACCESS, a legal read SHALL capture gpio_rdata into the response register.
REQ-035 A write or an illegal access SHALL load 0 into the response register.
REQ-036 In DONE: the owner's mK_done=1, mK_rdata=response register, mK_err=illegal flag.
REQ-037 The non-owner's mK_done, mK_rdata and mK_err SHALL be 0.
REQ-038 Latency SHALL be fixed: req sampled in IDLE at edge N, gnt high during cycle N+1, done high during cycle N+2.
REQ-039 Maximum throughput SHALL be one transaction per 3 cycles.

Reset
REQ-040 While rst_n=0: state=IDLE and pointer=requester 0.
REQ-041 While rst_n=0: all outputs, latched request fields and the response register SHALL be 0.
REQ-042 Reset assertion mid-ACCESS or mid-DONE SHALL drop gpio_cs/we/re and mK_done immediately (asynchronous), with no completion pulse.
REQ-043 The first rising edge with rst_n=1 SHALL evaluate IDLE arbitration.

Verification
REQ-044 m0 writes 0xA5A5_0001 to addr 0x00 -> m0_gnt in cycle N+1, with gpio_cs=1, gpio_we=1, gpio_wdata=0xA5A5_0001 in that cycle; then m0_done=1, m0_err=0, m0_rdata=0.
REQ-045 m1 reads addr 0x08 with gpio_rdata=0x0000_00F0 -> m1_gnt plus gpio_re=1; then m1_done=1, m1_rdata=0x0000_00F0, m1_err=0.
REQ-046 m0 and m1 held high together for 6 transactions after reset -> grant order m0, m1, m0, m1, m0, m1; gnt pulses exactly 3 cycles apart.
REQ-047 m0 writes addr 0x08, then reads addr 0x0C -> gpio_cs stays 0 for both; each DONE gives m0_err=1, m0_rdata=0.
REQ-048 rst_n pulled low during ACCESS of an m1 write -> gpio_cs and gpio_we fall without a clock edge; no m1_done.
REQ-049 Continuing REQ-048: after release with only m1_req high -> m1 is granted (lone requester); pointer is back at m0.
